// File: rtl/signed_div_ctrl.sv
// signed_div_ctrl: request/response front end for the 32-bit iterative
// unsigned divider core. Converts signed operands to magnitudes, drives the
// core's start/a/b, waits out the core latency, sign-corrects q/r and handles
// divide-by-zero before presenting the result over a valid/ready channel.
module signed_div_ctrl #(
  parameter int unsigned DIV_LATENCY = 33
) (
  input  logic        clock,
  input  logic        reset,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_signed,
  // response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_q,
  output logic [31:0] resp_r,
  output logic        resp_dbz,
  // divider core interface
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;

  localparam logic [CW-1:0] CNT_FLUSH = CW'(DIV_LATENCY);
  localparam logic [CW-1:0] CNT_WAIT  = CW'(DIV_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_quo_q, sign_quo_d;
  logic            sign_rem_q, sign_rem_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_quo_q, resp_quo_d;
  logic [DW-1:0]   resp_rem_q, resp_rem_d;
  logic            resp_dbz_q, resp_dbz_d;
  logic            div_start_q, div_start_d;
  logic [DW-1:0]   div_a_q, div_a_d;
  logic [DW-1:0]   div_b_q, div_b_d;

  logic [DW-1:0]   a_mag_c;
  logic [DW-1:0]   b_mag_c;
  logic [DW-1:0]   q_fix_c;
  logic [DW-1:0]   r_fix_c;
  logic            accept_c;

  // Operand magnitudes (mod 2^32, so |MIN| stays MIN) and result sign fix-up.
  always_comb begin
    a_mag_c  = (req_signed && req_a[DW-1]) ? (~req_a + DW'(1)) : req_a;
    b_mag_c  = (req_signed && req_b[DW-1]) ? (~req_b + DW'(1)) : req_b;
    q_fix_c  = sign_quo_q ? (DW'(0) - div_q) : div_q;
    r_fix_c  = sign_rem_q ? (DW'(0) - div_r) : div_r;
    accept_c = req_valid && req_ready_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sign_quo_d   = sign_quo_q;
    sign_rem_d   = sign_rem_q;
    resp_quo_d   = resp_quo_q;
    resp_rem_d   = resp_rem_q;
    resp_dbz_d   = resp_dbz_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_start_d  = 1'b0;

    unique case (state_q)
      // The core has no reset and ignores start mid-iteration, so let any
      // in-progress divide drain before the first start pulse.
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_IDLE: begin
        if (accept_c) begin
          sign_quo_d = req_signed && (req_a[DW-1] ^ req_b[DW-1]);
          sign_rem_d = req_signed && req_a[DW-1];
          if (req_b == '0) begin
            resp_quo_d = '1;
            resp_rem_d = req_a;
            resp_dbz_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            div_a_d     = a_mag_c;
            div_b_d     = b_mag_c;
            div_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_WAIT;
        state_d = ST_WAIT;
      end

      // div_b stays put here because the core compares against the live value.
      ST_WAIT: begin
        if (cnt_q == '0) begin
          resp_quo_d = q_fix_c;
          resp_rem_d = r_fix_c;
          resp_dbz_d = 1'b0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_RESP: begin
        if (resp_valid_q && resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_FLUSH;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FLUSH;
      cnt_q        <= CNT_FLUSH;
      sign_quo_q   <= 1'b0;
      sign_rem_q   <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_quo_q   <= '0;
      resp_rem_q   <= '0;
      resp_dbz_q   <= 1'b0;
      div_start_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sign_quo_q   <= sign_quo_d;
      sign_rem_q   <= sign_rem_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_quo_q   <= resp_quo_d;
      resp_rem_q   <= resp_rem_d;
      resp_dbz_q   <= resp_dbz_d;
      div_start_q  <= div_start_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_q     = resp_quo_q;
  assign resp_r     = resp_rem_q;
  assign resp_dbz   = resp_dbz_q;
  assign div_start  = div_start_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;

endmodule

// File: tb/tb_signed_div_ctrl.sv
// Directed bench for signed_div_ctrl with a behavioural model of the
// iterative divider core (33-edge latency, ignores start while busy,
// compares against live b).
module tb_signed_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_q;
  logic [31:0] resp_r;
  logic        resp_dbz;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_q;
  logic [31:0] div_r;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  always #5 clock = ~clock;

  signed_div_ctrl #(.DIV_LATENCY(33)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_q     (resp_q),
    .resp_r     (resp_r),
    .resp_dbz   (resp_dbz),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_q      (div_q),
    .div_r      (div_r)
  );

  // Core model: q/r carry junk until the 33rd edge after the sampling edge.
  logic [31:0] m_a    = 32'h0;
  logic [5:0]  m_cnt  = 6'd0;
  logic [31:0] core_q = 32'h0;
  logic [31:0] core_r = 32'h0;

  always @(posedge clock) begin
    if (m_cnt == 6'd0) begin
      if (div_start === 1'b1) begin
        m_a    <= div_a;
        m_cnt  <= 6'd32;
        core_q <= 32'hDEAD0000;
        core_r <= 32'hBEEF0000;
      end
    end else if (m_cnt == 6'd1) begin
      m_cnt  <= 6'd0;
      core_q <= (div_b == 32'h0) ? 32'hFFFFFFFF : m_a / div_b;
      core_r <= (div_b == 32'h0) ? m_a : m_a % div_b;
    end else begin
      m_cnt  <= m_cnt - 6'd1;
      core_q <= core_q + 32'h1;
      core_r <= core_r + 32'h3;
    end
  end

  assign div_q = core_q;
  assign div_r = core_r;

  always @(posedge clock) begin
    if (div_start === 1'b1) starts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Count cycles from reset release until req_ready; no response may appear.
  task automatic measure_flush(input string tag);
    int n;
    int spurious;
    n = 0;
    spurious = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      if (resp_valid !== 1'b0) spurious++;
      @(negedge clock);
      n++;
    end
    check({tag, "_flush_cycles"}, 32'(n), 32'd34);
    check({tag, "_no_resp"}, 32'(spurious), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Issue one request and wait for the response (not yet consumed).
  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat);
    int n;
    int st_at;
    int s0;
    wait_ready(tag);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_signed = s;
    s0 = starts;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_a     = 32'hA5A5A5A5;
    req_b     = 32'h5A5A5A5A;
    req_signed = ~s;
    n = 1;
    st_at = (div_start === 1'b1) ? 1 : 0;
    while (resp_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
      if (div_start === 1'b1 && st_at == 0) st_at = n;
    end
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_q"}, resp_q, eq);
    check({tag, "_r"}, resp_r, er);
    check({tag, "_dbz"}, {31'd0, resp_dbz}, {31'd0, edbz});
    check({tag, "_starts"}, 32'(starts - s0), edbz ? 32'd0 : 32'd1);
    check({tag, "_start_cycle"}, 32'(st_at), edbz ? 32'd0 : 32'd1);
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_a      = 32'h0;
    req_b      = 32'h0;
    req_signed = 1'b0;
    resp_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Reset values
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_q", resp_q, 32'h0);
    check("rst_resp_r", resp_r, 32'h0);
    check("rst_resp_dbz", {31'd0, resp_dbz}, 32'd0);
    check("rst_div_start", {31'd0, div_start}, 32'd0);
    check("rst_div_a", div_a, 32'h0);
    check("rst_div_b", div_b, 32'h0);

    reset = 1'b0;
    measure_flush("init");

    // 1. Unsigned 100/7
    run_req("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35);
    check("u100_7_div_a", div_a, 32'd100);
    check("u100_7_div_b", div_b, 32'd7);
    finish_resp("u100_7");

    // 2. Signed sign correction
    run_req("sm7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 35);
    check("sm7_2_div_a", div_a, 32'd7);
    check("sm7_2_div_b", div_b, 32'd2);
    finish_resp("sm7_2");
    run_req("s7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 35);
    finish_resp("s7_m2");
    run_req("sm100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0, 35);
    finish_resp("sm100_m7");

    // 3. Divide by zero, both modes
    run_req("dbz_u", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
    finish_resp("dbz_u");
    run_req("dbz_s", 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
    finish_resp("dbz_s");
    run_req("dbz_sneg", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1);
    finish_resp("dbz_sneg");

    // 4. Boundaries
    run_req("smin_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 35);
    check("smin_m1_div_a", div_a, 32'h80000000);
    check("smin_m1_div_b", div_b, 32'd1);
    finish_resp("smin_m1");
    run_req("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 35);
    finish_resp("umax_1");
    run_req("umin_max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0, 35);
    finish_resp("umin_max");

    // 5. Back-pressure with a competing request pending
    run_req("bp", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 35);
    begin
      int s0;
      s0 = starts;
      req_valid = 1'b1;
      req_a     = 32'd9;
      req_b     = 32'd3;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
        check("bp_hold_q", resp_q, 32'd30);
        check("bp_hold_r", resp_r, 32'd10);
        check("bp_hold_dbz", {31'd0, resp_dbz}, 32'd0);
        check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      check("bp_no_start", 32'(starts - s0), 32'd0);
    end
    finish_resp("bp");

    // 6. Reset in cycle N+10 of a divide
    wait_ready("mid");
    req_valid  = 1'b1;
    req_a      = 32'd100;
    req_b      = 32'd7;
    req_signed = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    measure_flush("mid");
    run_req("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 35);
    finish_resp("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
